// File: rtl/canon_sequencer_if.sv
// Control, note-ROM and note-stream signals of canon_sequencer.
// The master side drives control and ROM data. The slave side is the sequencer.
interface canon_sequencer_if #(
  parameter int VOICES = 3,
  parameter int ROM_AW = 9
);
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [VOICES-1:0] voice_en;
  logic [ROM_AW-1:0] rom_addr;
  logic [6:0]        rom_data;
  logic              note_valid;
  logic [2:0]        note_slot;
  logic [4:0]        note_code;
  logic [6:0]        crotchet;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, loop_en, voice_en, rom_data,
    input  rom_addr, note_valid, note_slot, note_code, crotchet, busy, done
  );

  modport slave (
    input  start, stop, loop_en, voice_en, rom_data,
    output rom_addr, note_valid, note_slot, note_code, crotchet, busy, done
  );
endinterface

// File: rtl/canon_sequencer.sv
// Multi-voice canon sequencer: one bass slot plus VOICES lagging voices share a
// single note ROM through a round-robin slot counter, emitting tagged note codes.
module canon_sequencer #(
  parameter int VOICES        = 3,
  parameter int ROM_AW        = 9,
  parameter int BEAT_W        = 22,
  parameter int VOICE_LAG     = 8,
  parameter int LOOP_START    = 8,
  parameter int LOOP_END      = 287,
  parameter int BASS_BASE     = 504,
  parameter int BASS_LEN_LOG2 = 3
) (
  input logic              clk,
  input logic              rst_n,
  canon_sequencer_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
  typedef logic [ROM_AW-1:0] addr_t;

  localparam addr_t      LOOP_START_A = addr_t'(LOOP_START);
  localparam addr_t      LOOP_END_A   = addr_t'(LOOP_END);
  localparam addr_t      BASS_BASE_A  = addr_t'(BASS_BASE);
  localparam logic [2:0] LAST_SLOT    = 3'(VOICES);

  // Voice i enters VOICE_LAG*(i-1) entries behind voice 1, wrapping below zero.
  function automatic addr_t ptr_init(input int voice);
    return addr_t'(LOOP_START - VOICE_LAG * (voice - 1));
  endfunction

  // Mask of sub-beat bits that must be zero for the note to end.
  function automatic logic [2:0] dur_decode(input logic [1:0] code);
    case (code)
      2'b00:   return 3'b000;
      2'b01:   return 3'b001;
      2'b10:   return 3'b111;
      default: return 3'b011;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              enter, run, busy_c, done_c;
  logic              all_fin, sub_pulse, muted;
  logic [2:0]        slot_q;
  logic [BEAT_W-1:0] tick_q;
  logic [2:0]        sub_q, sub_next;
  logic [6:0]        crotchet_q;
  addr_t             addr_c;

  addr_t             ptr_q      [1:VOICES];
  logic [2:0]        dur_mask_q [1:VOICES];
  logic [VOICES:1]   pending_q;
  logic [VOICES:1]   fin_q;

  logic              note_valid_q;
  logic [2:0]        note_slot_q;
  logic [4:0]        note_code_q;

  assign all_fin = &fin_q;

  // ---------------------------------------------------------------- FSM
  // NOTE: state is updated with <= so every flop samples pre-edge values;
  // a blocking = here would create order-dependent races between processes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && !bus.stop) state_d = PLAY;
      PLAY:    if (bus.stop || all_fin)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // run excludes the leaving cycle so everything freezes the moment we stop.
  always_comb begin
    enter  = (state_q == IDLE) && (state_d == PLAY);
    run    = (state_q == PLAY) && (state_d == PLAY);
    busy_c = (state_q == PLAY);
    done_c = (state_q == PLAY) && all_fin;
  end

  // ------------------------------------------------------ slot and beats
  assign sub_pulse = run && (&tick_q);
  assign sub_next  = sub_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q     <= '0;
      tick_q     <= '0;
      sub_q      <= '0;
      crotchet_q <= '0;
    end else begin
      slot_q <= (run && slot_q != LAST_SLOT) ? slot_q + 3'd1 : 3'd0;
      if (enter) begin
        tick_q     <= '0;
        sub_q      <= '0;
        crotchet_q <= '0;
      end else if (run) begin
        tick_q <= tick_q + BEAT_W'(1);
        if (sub_pulse) begin
          sub_q <= sub_next;
          if (sub_q == 3'd7) crotchet_q <= crotchet_q + 7'd1;
        end
      end
    end
  end

  // -------------------------------------------------------------- voices
  // NOTE: the per-voice arrays are small and reset explicitly, because the
  // pointers must hold their entry values straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i <= VOICES; i++) begin
        ptr_q[i]      <= ptr_init(i);
        dur_mask_q[i] <= '0;
      end
      pending_q <= '0;
      fin_q     <= '0;
    end else if (enter) begin
      for (int i = 1; i <= VOICES; i++) begin
        ptr_q[i]      <= ptr_init(i);
        dur_mask_q[i] <= '0;
      end
      pending_q <= '0;
      fin_q     <= '0;
    end else if (run) begin
      for (int i = 1; i <= VOICES; i++) begin
        if (slot_q == 3'(i)) begin
          dur_mask_q[i] <= dur_decode(bus.rom_data[6:5]);
          if (pending_q[i]) begin
            if (ptr_q[i] == LOOP_END_A) begin
              if (bus.loop_en) ptr_q[i] <= LOOP_START_A;
              else             fin_q[i] <= 1'b1;
            end else begin
              ptr_q[i] <= ptr_q[i] + addr_t'(1);
            end
          end
        end
        // A fresh sub-beat request outranks the clear of one just consumed.
        if (sub_pulse && ((sub_next & dur_mask_q[i]) == 3'b000))
          pending_q[i] <= 1'b1;
        else if (slot_q == 3'(i))
          pending_q[i] <= 1'b0;
      end
    end
  end

  // ------------------------------------------------ ROM address and mute
  always_comb begin
    addr_c = BASS_BASE_A + addr_t'(crotchet_q[BASS_LEN_LOG2-1:0]);
    muted  = 1'b0;
    for (int i = 1; i <= VOICES; i++) begin
      if (slot_q == 3'(i)) begin
        addr_c = ptr_q[i];
        muted  = !bus.voice_en[i-1];
      end
    end
  end

  // -------------------------------------------------------- note output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_valid_q <= 1'b0;
      note_slot_q  <= '0;
      note_code_q  <= '0;
    end else if (run) begin
      note_valid_q <= 1'b1;
      note_slot_q  <= slot_q;
      note_code_q  <= muted ? 5'd0 : bus.rom_data[4:0];
    end else begin
      note_valid_q <= 1'b0;
      note_slot_q  <= '0;
      note_code_q  <= '0;
    end
  end

  assign bus.rom_addr   = addr_c;
  assign bus.note_valid = note_valid_q;
  assign bus.note_slot  = note_slot_q;
  assign bus.note_code  = note_code_q;
  assign bus.crotchet   = crotchet_q;
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;

endmodule

// File: doc/canon_sequencer.md
# canon_sequencer

Parametrised multi-voice note sequencer for the audio path. It time-multiplexes one bass slot and `VOICES` canon voices over a single external note ROM. Each voice walks the ROM at its own pace, set by per-note duration codes, and the voices enter with a fixed lag. The block emits a tagged note code per slot to the downstream divider/PWM stage and adds start/stop control, per-voice mute and optional looping.

## Interface

**Parameters**

- `VOICES`, 3: canon voices, 1..7. Slot count is `VOICES+1`.
- `ROM_AW`, 9: ROM address width and voice pointer width.
- `BEAT_W`, 22: one sub-beat lasts 2^BEAT_W clocks. Minimum 4.
- `VOICE_LAG`, 8: entry lag in ROM entries between successive voices.
- `LOOP_START`, 8: first melody address.
- `LOOP_END`, 287: last melody address.
- `BASS_BASE`, 504: base address of the bass line.
- `BASS_LEN_LOG2`, 3: the bass line has 2^BASS_LEN_LOG2 entries.

**Ports**

- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: level-sampled start request.
- `stop` in 1: level-sampled stop request.
- `loop_en` in 1: 1 = voices wrap at the end of the melody; 0 = voices stop there.
- `voice_en` in VOICES: bit i-1 unmutes voice i.
- `rom_addr` out ROM_AW: combinational ROM address for the current slot.
- `rom_data` in 7: ROM word, valid in the same cycle. Bits [6:5] are the duration code, bits [4:0] the note code.
- `note_valid` out 1: `note_slot`/`note_code` hold a fresh value.
- `note_slot` out 3: slot tag. 0 = bass, i = voice i.
- `note_code` out 5: note code. 0 = rest.
- `crotchet` out 7: beat counter.
- `busy` out 1: high in PLAY.
- `done` out 1: one-cycle pulse when a non-looping play completes.

## Operation

**States**
- IDLE→PLAY on `start`.
- PLAY→IDLE on `stop`, or on completion.
- `start` in PLAY is ignored. `stop` in IDLE is ignored. If `start` and `stop` are high together, `stop` wins.

**Entering PLAY (from IDLE)**
- `tick`, `sub` and `crotchet` are cleared.
- Pointer `ptr[i]` = (LOOP_START − VOICE_LAG·(i−1)) mod 2^ROM_AW.
- `dur_mask[i]` = 0 and `pending[i]` = 0 for every voice.

**Slot counter**
- Counts 0..VOICES and wraps to 0. It runs only in PLAY and is held at 0 in IDLE.

**ROM address**
- Slot 0: `rom_addr` = BASS_BASE + `crotchet[BASS_LEN_LOG2-1:0]`, truncated to ROM_AW bits.
- Slot i: `rom_addr` = `ptr[i]`.

**Beat counters**
- `tick` is a BEAT_W-bit counter.
- Sub-beat pulse when `tick` = all-ones.
- `sub` is 3 bits and increments on each sub-beat pulse.
- `crotchet` increments when `sub` wraps from 7 to 0, and wraps mod 128.

**Duration mask**
- At slot i, `dur_mask[i]` is loaded from `rom_data[6:5]`:
  - 00 → 000
  - 01 → 001
  - 10 → 111
  - 11 → 011
- Note lengths are therefore 1, 2, 8 and 4 sub-beats.

**Pending flags**
- On a sub-beat pulse, `pending[i]` is set if (`sub_next` & `dur_mask[i]`) == 0.

**Pointer advance**
- At slot i with `pending[i]` set: `pending[i]` is cleared and `ptr[i]` advances.
- A normal advance is `ptr[i]` + 1, mod 2^ROM_AW.
- If `ptr[i]` == LOOP_END:
  - with `loop_en` = 1, `ptr[i]` becomes LOOP_START;
  - with `loop_en` = 0, `ptr[i]` holds and `fin[i]` is set.
- A lagging voice passes through the pre-start addresses, mod 2^ROM_AW. Those addresses must hold rests; this is a ROM content rule.

**Completion**
- When all `fin[i]` are 1: go to IDLE and pulse `done`.
- `fin[i]` is cleared on entering PLAY.

**Output**
- Registered. In PLAY each cycle: `note_valid` = 1, `note_slot` = slot, `note_code` = `rom_data[4:0]`.
- A voice whose `voice_en` bit is 0 outputs `note_code` 0. Its pointer still advances, so unmuting it keeps the canon aligned.
- `voice_en` is sampled on every slot.

## Timing

**Reset values**
- `note_valid`, `note_slot`, `note_code`, `crotchet`, `busy` and `done` are 0, and the state is IDLE.
- Pointers take their PLAY-entry values.

**Start latency**
- `start` sampled high in cycle n gives PLAY in n+1, `busy` = 1 from n+1.
- `rom_addr` shows slot 0 in n+1.
- The first `note_valid` (slot 0) appears in n+2.

**Output latency**
- `note_*` appear exactly 1 cycle after the `rom_addr` that produced them.

**Stop and completion**
- In the cycle after `stop`, or after completion, `busy` = 0 and `note_valid` = 0. Counters and pointers are frozen until the next `start`.

**Advance bound**
- After a sub-beat pulse, every pending advance completes within VOICES+1 cycles, well inside one sub-beat.

**Reset mid-play**
- An asynchronous reset during PLAY returns the block to the reset values immediately. No `done` pulse is generated.

## Test plan

Bench settings: BEAT_W = 4, VOICES = 3, and a ROM model with every duration code 00 unless a scenario states otherwise.

- **Reset:** assert `rst_n` = 0 mid-PLAY → all outputs 0 in the same cycle, no `done`; `start` after release → voice 1 reads address 8, voice 2 address 0, voice 3 address 504.
- **Slot order and latency:** `start` at cycle 10 → `note_slot` runs 0,1,2,3,0,… from cycle 12; `note_code` equals the ROM word at the address one cycle earlier.
- **Durations:**
  - ROM[8] code 10 → `ptr[1]` stays at 8 for 8 sub-beats (128 clocks), then becomes 9.
  - Code 01 → 2 sub-beats.
  - Code 11 → 4 sub-beats.
- **Looping:**
  - `loop_en` = 1, `ptr[1]` at 287 when it advances → 8.
  - `loop_en` = 0 → `ptr[1]` holds at 287; `done` pulses once voice 3 reaches 287, and `busy` falls the next cycle.
- **Mute:** `voice_en` = 3'b101 → slot-2 `note_code` is 0 while `ptr[2]` keeps advancing; restoring 3'b111 → slot 2 plays the ROM word at its current pointer.
- **Control corner cases:**
  - `start` and `stop` high together in IDLE → stays IDLE.
  - `start` pulsed again in PLAY → counters unaffected.
  - `crotchet` wraps 127 → 0 with the bass address following `crotchet[2:0]`.
